// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin front end sharing one GCD custom-instruction unit between two requesters.
// Zero operands bypass the unit; a stalled unit is abandoned after TIMEOUT wait cycles.
module gcd_arbiter #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_result,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_result,
  output logic        rsp1_err,
  output logic        gcd_clk_en,
  output logic        gcd_start,
  output logic [31:0] gcd_dataa,
  output logic [31:0] gcd_datab,
  input  logic [31:0] gcd_result,
  input  logic        gcd_done,
  output logic        busy,
  output logic        owner
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t state;
  logic last;
  logic [CW-1:0] cnt;
  logic [31:0] res;
  logic err;
  logic take, grant;
  logic [31:0] sa, sb;
  always_comb begin
    take = (state == IDLE) && (req0_valid || req1_valid);
    grant = (req0_valid && req1_valid) ? ~last : req1_valid;
    sa = grant ? req1_a : req0_a;
    sb = grant ? req1_b : req0_b;
  end
  assign req0_ready = take && !grant;
  assign req1_ready = take && grant;
  assign rsp0_result = res;
  assign rsp1_result = res;
  assign rsp0_err = err;
  assign rsp1_err = err;
  // last starts at 1 so requester 0 wins the first tie after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last <= 1'b1;
      cnt <= '0;
      res <= '0;
      err <= 1'b0;
      owner <= 1'b0;
      busy <= 1'b0;
      gcd_clk_en <= 1'b0;
      gcd_start <= 1'b0;
      gcd_dataa <= '0;
      gcd_datab <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          last <= grant;
          owner <= grant;
          busy <= 1'b1;
          gcd_dataa <= sa;
          gcd_datab <= sb;
          if (sa == 32'd0 || sb == 32'd0) begin
            state <= RESP;
            res <= sa | sb;
            err <= (sa == 32'd0) && (sb == 32'd0);
            rsp0_valid <= !grant;
            rsp1_valid <= grant;
          end else begin
            state <= LAUNCH;
            gcd_clk_en <= 1'b1;
            gcd_start <= 1'b1;
          end
        end
        LAUNCH: begin
          state <= WAIT;
          gcd_start <= 1'b0;
          cnt <= '0;
        end
        WAIT: if (gcd_done || cnt == CW'(TIMEOUT - 1)) begin
          state <= RESP;
          gcd_clk_en <= 1'b0;
          res <= gcd_done ? gcd_result : 32'd0;
          err <= !gcd_done;
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: begin
          state <= IDLE;
          busy <= 1'b0;
          owner <= 1'b0;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed and randomized jobs against a job-level reference model,
// with a behavioural GCD unit whose run length (or stall) is chosen per job.
module tb_gcd_arbiter;
  localparam int TO = 16;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result, gcd_dataa, gcd_datab;
  logic gcd_clk_en, gcd_start, busy, owner;
  logic [31:0] gcd_result = 0;
  logic gcd_done = 0;
  int lat = 1, rem = 0;
  int n_chk = 0, n_pass = 0;
  int last_w = 1;
  logic nv [2];
  logic [31:0] na [2], nb [2];

  gcd_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
    .gcd_clk_en(gcd_clk_en), .gcd_start(gcd_start), .gcd_dataa(gcd_dataa), .gcd_datab(gcd_datab),
    .gcd_result(gcd_result), .gcd_done(gcd_done), .busy(busy), .owner(owner));

  always #5 clk = ~clk;

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a, y = b, t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // GCD unit: done is sticky until clk_en drops; lat=0 models a hung unit
  always @(posedge clk) begin
    if (!gcd_clk_en) begin
      gcd_done <= 0;
      rem <= 0;
    end else if (gcd_start) begin
      gcd_result <= gcd_ref(gcd_dataa, gcd_datab);
      gcd_done <= (lat == 1);
      rem <= (lat > 1) ? lat - 1 : 0;
    end else if (rem != 0) begin
      rem <= rem - 1;
      if (rem == 1) gcd_done <= 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b);
    nv[n] = 1;
    na[n] = a;
    nb[n] = b;
  endtask

  task automatic do_job();
    int w, k, starts, elat;
    logic [31:0] ea, eb, er, sa, sb;
    logic ee, fin;
    @(negedge clk);
    if (nv[0]) begin req0_valid = 1; req0_a = na[0]; req0_b = nb[0]; nv[0] = 0; end
    if (nv[1]) begin req1_valid = 1; req1_a = na[1]; req1_b = nb[1]; nv[1] = 0; end
    #1;
    w = (req0_valid && req1_valid) ? 1 - last_w : int'(req1_valid);
    chk("idle_busy", {busy, owner, gcd_clk_en}, 0);
    chk("ready", {req1_ready, req0_ready}, w ? 2 : 1);
    last_w = w;
    ea = w ? req1_a : req0_a;
    eb = w ? req1_b : req0_b;
    if (ea == 0 || eb == 0) begin
      er = ea | eb; ee = (ea == 0 && eb == 0); elat = 1;
    end else if (lat >= 1 && lat <= TO) begin
      er = gcd_ref(ea, eb); ee = 0; elat = 2 + lat;
    end else begin
      er = 0; ee = 1; elat = 2 + TO;
    end
    k = 0; starts = 0; fin = 0; sa = 0; sb = 0;
    while (!fin && k < 60) begin
      @(negedge clk);
      if (k == 0) begin
        if (w) req1_valid = 0;
        else req0_valid = 0;
      end
      #1;
      k++;
      if (gcd_start) begin starts++; sa = gcd_dataa; sb = gcd_datab; end
      if (rsp0_valid || rsp1_valid) fin = 1;
    end
    chk("rsp_seen", fin, 1);
    chk("rsp_chan", {rsp1_valid, rsp0_valid}, w ? 2 : 1);
    chk("result", w ? rsp1_result : rsp0_result, er);
    chk("err", w ? rsp1_err : rsp0_err, ee);
    chk("latency", k, elat);
    chk("starts", starts, (elat == 1) ? 0 : 1);
    if (starts != 0) chk("start_ops", {sa[15:0], sb[15:0]}, {ea[15:0], eb[15:0]});
    chk("owner_busy", {owner, busy}, {w[0], 1'b1});
    chk("hold_dataa", gcd_dataa, ea);
  endtask

  initial begin
    nv[0] = 0; nv[1] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", {busy, owner, gcd_clk_en, gcd_start, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("post_rst_idle", {busy, gcd_clk_en}, 0);
    lat = 3; set_req(0, 48, 18); do_job();
    lat = 2; set_req(0, 21, 14); set_req(1, 35, 10); do_job(); do_job();
    lat = 4; set_req(0, 21, 14); set_req(1, 35, 10); do_job(); do_job();
    set_req(1, 0, 35); do_job();
    set_req(0, 0, 0); do_job();
    lat = 0; set_req(0, 100, 75); do_job();
    lat = 2; set_req(0, 9, 6); do_job();
    lat = TO; set_req(1, 44, 121); do_job();
    lat = TO + 1; set_req(0, 44, 121); do_job();
    lat = 0;
    @(negedge clk);
    req0_valid = 1; req0_a = 1000000; req0_b = 3;
    #1;
    chk("drop_ready", {req1_ready, req0_ready}, 1);
    @(negedge clk);
    req0_valid = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_wait", {busy, gcd_clk_en}, 2'b11);
    rst_n = 0;
    #1;
    chk("async_rst", {busy, owner, gcd_clk_en, gcd_start, rsp0_valid, rsp1_valid, rsp0_err}, 0);
    chk("async_rst_ops", gcd_dataa | gcd_datab | rsp0_result, 0);
    @(negedge clk);
    rst_n = 1;
    last_w = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid || rsp1_valid || gcd_clk_en) chk("dropped_job_quiet", {rsp0_valid, rsp1_valid, gcd_clk_en}, 0);
    end
    chk("after_drop_idle", {busy, rsp0_valid}, 0);
    lat = 2; set_req(1, 12, 8); do_job();
    for (int i = 0; i < 40; i++) begin
      int r;
      for (int n = 0; n < 2; n++) begin
        logic busy_n;
        busy_n = n ? req1_valid : req0_valid;
        if (!busy_n && $urandom_range(0, 1) == 1) begin
          logic [31:0] g, a, b;
          g = $urandom_range(1, 60);
          a = g * $urandom_range(0, 40);
          b = g * $urandom_range(1, 40);
          if ($urandom_range(0, 7) == 0) a = 0;
          if ($urandom_range(0, 9) == 0) b = 0;
          set_req(n, a, b);
        end
      end
      if (!req0_valid && !req1_valid && !nv[0] && !nv[1]) set_req(0, $urandom_range(1, 999), $urandom_range(1, 999));
      r = $urandom_range(0, 11);
      lat = (r == 0) ? 0 : (r == 1) ? TO : (r == 2) ? TO + 1 : $urandom_range(1, 6);
      do_job();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
